hold_reg_bank: RTL

//   Parametrised, clocked successor of the 8-bit transparent latch: CHANNELS x WIDTH holding registers.

---
 rtl/hold_reg_pkg.sv | 14 +
 rtl/hold_reg_slot.sv | 56 +++++
 rtl/hold_reg_bank.sv | 104 ++++++++++
 3 files changed

// File: rtl/hold_reg_pkg.sv
// Shared types and helpers for the double-buffered holding register bank.
package hold_reg_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_COMMIT = 1'b1
    } state_e;

    // Address width for a channel count; never below one bit.
    function automatic int unsigned addr_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hold_reg_slot.sv
// One channel: shadow register, active register and optional pending-change flag.
// The flag exists only when HOLD_BANK_DIRTY_EN is defined.
module hold_reg_slot #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             ld,
    input  logic             xfer,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             dirty
);

    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] r_active;

    // Transfer reads the pre-clear shadow because both update on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shadow <= '0;
            r_active <= '0;
        end else begin
            if (xfer) begin
                r_active <= r_shadow;
            end
            if (clr) begin
                r_shadow <= '0;
            end else if (ld) begin
                r_shadow <= d;
            end
        end
    end

    assign q = r_active;

`ifdef HOLD_BANK_DIRTY_EN
    logic r_dirty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dirty <= 1'b0;
        end else if (clr || xfer) begin
            r_dirty <= 1'b0;
        end else if (ld) begin
            r_dirty <= 1'b1;
        end
    end

    assign dirty = r_dirty;
`else
    assign dirty = 1'b0;
`endif

endmodule

// File: rtl/hold_reg_bank.sv
// CHANNELS x WIDTH double-buffered holding registers with atomic commit.
// Optional per-channel dirty flags enabled by HOLD_BANK_DIRTY_EN.
module hold_reg_bank
    import hold_reg_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    localparam int unsigned AW      = addr_w(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic                      wr_auto,
    input  logic [AW-1:0]             wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      commit,
    output logic                      commit_done,
    output logic                      wr_err,
    output logic [AW-1:0]             ptr,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS-1:0]       dirty
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic              w_xfer;
    logic              w_acc;
    logic              w_bad;
    logic [AW-1:0]     w_tgt;
    logic [AW-1:0]     r_ptr;
    logic              r_done;
    logic              r_err;
    logic [CHANNELS-1:0] w_ld;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Commit holds off writes for exactly one cycle while the transfer happens.
    always_comb begin
        w_state_nxt = r_state;
        wr_ready    = 1'b0;
        w_xfer      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                wr_ready = rst_n;
                if (commit) begin
                    w_state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                w_xfer      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_acc = wr_valid && wr_ready;
    assign w_tgt = wr_auto ? r_ptr : wr_addr;
    assign w_bad = !wr_auto && ({1'b0, wr_addr} >= (AW+1)'(CHANNELS));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr  <= '0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= w_xfer;
            r_err  <= w_acc && w_bad;
            if (clr) begin
                r_ptr <= '0;
            end else if (w_acc && wr_auto) begin
                r_ptr <= (r_ptr == AW'(CHANNELS - 1)) ? '0 : r_ptr + AW'(1);
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_slot
        assign w_ld[i] = w_acc && !w_bad && (w_tgt == AW'(i));

        hold_reg_slot #(.WIDTH(WIDTH)) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .ld    (w_ld[i]),
            .xfer  (w_xfer),
            .d     (wr_data),
            .q     (q[i*WIDTH +: WIDTH]),
            .dirty (dirty[i])
        );
    end

    assign ptr         = r_ptr;
    assign commit_done = r_done;
    assign wr_err      = r_err;

endmodule
